// File: rtl/boreal_pkg.sv
// Shared constants and types for the boreal weight-memory blocks.
package boreal_pkg;

  localparam int unsigned ADDR_WIDTH_DEF  = 10;
  localparam int unsigned DATA_WIDTH_DEF  = 16;
  localparam int unsigned TRACE_WIDTH_DEF = 8;

  typedef logic signed [DATA_WIDTH_DEF-1:0] weight_t;

  typedef struct packed {
    logic                       valid;
    logic [ADDR_WIDTH_DEF-1:0]  addr;
    logic [TRACE_WIDTH_DEF-1:0] pre;
    logic [TRACE_WIDTH_DEF-1:0] post;
    logic                       depress;
  } stage_t;

endpackage

// File: rtl/boreal_hebb_delta.sv
// Combinational Hebbian update: trace product, learning-rate shift, signed add, clamp.
module boreal_hebb_delta #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TRACE_WIDTH = 8,
  parameter int unsigned LR_SHIFT    = 4,
  parameter int          W_MAX       = 32767,
  parameter int          W_MIN       = -32768
) (
  input  logic [TRACE_WIDTH-1:0]       pre,
  input  logic [TRACE_WIDTH-1:0]       post,
  input  logic                         depress,
  input  logic signed [DATA_WIDTH-1:0] w,
  output logic signed [DATA_WIDTH-1:0] result
);

  // Two guard bits so the add can never wrap before the clamp.
  localparam int unsigned SumW = DATA_WIDTH + 2;
  localparam logic signed [SumW-1:0] WMaxExt = SumW'(W_MAX);
  localparam logic signed [SumW-1:0] WMinExt = SumW'(W_MIN);

  logic [2*TRACE_WIDTH-1:0] product;
  logic [2*TRACE_WIDTH-1:0] shifted;
  logic signed [SumW-1:0]   delta;
  logic signed [SumW-1:0]   w_ext;
  logic signed [SumW-1:0]   sum;

  always_comb begin
    product = {{TRACE_WIDTH{1'b0}}, pre} * {{TRACE_WIDTH{1'b0}}, post};
    shifted = product >> LR_SHIFT;
    delta   = SumW'(shifted);
    w_ext   = SumW'(w);
    sum     = depress ? (w_ext - delta) : (w_ext + delta);
    if (sum > WMaxExt) begin
      result = WMaxExt[DATA_WIDTH-1:0];
    end else if (sum < WMinExt) begin
      result = WMinExt[DATA_WIDTH-1:0];
    end else begin
      result = sum[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/boreal_hebbian_updater.sv
// Four-stage read-modify-write Hebbian updater in front of the boreal weight BRAM.
// Same-address requests stall until the older update has reached the write stage.
module boreal_hebbian_updater
  import boreal_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned TRACE_WIDTH = TRACE_WIDTH_DEF,
  parameter int unsigned LR_SHIFT    = 4,
  parameter int          W_MAX       = 32767,
  parameter int          W_MIN       = -32768
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  input  logic [TRACE_WIDTH-1:0] in_pre,
  input  logic [TRACE_WIDTH-1:0] in_post,
  input  logic                   in_depress,
  output logic [ADDR_WIDTH-1:0]  addr_a,
  input  logic [DATA_WIDTH-1:0]  dout_a,
  output logic                   we_b,
  output logic [ADDR_WIDTH-1:0]  addr_b,
  output logic [DATA_WIDTH-1:0]  din_b,
  output logic                   busy
);

  stage_t                  s1_q, s2_q, s3_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_b_q;
  logic [DATA_WIDTH-1:0]   din_b_q;
  weight_t                 result;
  logic                    hazard;
  logic                    accept;

  boreal_hebb_delta #(
    .DATA_WIDTH  (DATA_WIDTH),
    .TRACE_WIDTH (TRACE_WIDTH),
    .LR_SHIFT    (LR_SHIFT),
    .W_MAX       (W_MAX),
    .W_MIN       (W_MIN)
  ) u_delta (
    .pre     (s3_q.pre),
    .post    (s3_q.post),
    .depress (s3_q.depress),
    .w       ($signed(dout_a)),
    .result  (result)
  );

  // S4 is excluded: its write lands before a newly accepted request reads.
  always_comb begin
    hazard = (s1_q.valid && (s1_q.addr == in_addr)) ||
             (s2_q.valid && (s2_q.addr == in_addr)) ||
             (s3_q.valid && (s3_q.addr == in_addr));
    in_ready = !hazard;
    accept   = in_valid && !hazard;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      we_q     <= 1'b0;
      addr_b_q <= '0;
      din_b_q  <= '0;
    end else begin
      s1_q.valid <= accept;
      if (accept) begin
        s1_q.addr    <= in_addr;
        s1_q.pre     <= in_pre;
        s1_q.post    <= in_post;
        s1_q.depress <= in_depress;
      end
      s2_q <= s1_q;
      s3_q <= s2_q;
      we_q <= s3_q.valid;
      if (s3_q.valid) begin
        addr_b_q <= s3_q.addr;
        din_b_q  <= result;
      end
    end
  end

  assign addr_a = s1_q.addr;
  assign we_b   = we_q;
  assign addr_b = addr_b_q;
  assign din_b  = din_b_q;
  assign busy   = s1_q.valid | s2_q.valid | s3_q.valid | we_q;

endmodule

// File: tb/tb_boreal_hebbian_updater.sv
// Self-checking bench: BRAM model, integer reference model and write scoreboard.
module tb_boreal_hebbian_updater;

  localparam int LrShift = 4;
  localparam int NumW    = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_addr;
  logic [7:0]  in_pre;
  logic [7:0]  in_post;
  logic        in_depress;
  logic [9:0]  addr_a;
  logic [15:0] dout_a;
  logic        we_b;
  logic [9:0]  addr_b;
  logic [15:0] din_b;
  logic        busy;

  logic [15:0] ram [0:1023];
  logic [15:0] rd1;
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [15:0] bd_data;

  int ref_w [0:NumW-1];
  int exp_addr[$];
  int exp_data[$];
  int checks = 0;
  int errors = 0;

  boreal_hebbian_updater dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_pre     (in_pre),
    .in_post    (in_post),
    .in_depress (in_depress),
    .addr_a     (addr_a),
    .dout_a     (dout_a),
    .we_b       (we_b),
    .addr_b     (addr_b),
    .din_b      (din_b),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // BRAM with 2-cycle read latency plus a bench backdoor write port.
  always @(posedge clk) begin
    rd1    <= ram[addr_a];
    dout_a <= rd1;
    if (we_b === 1'b1) ram[addr_b] <= din_b;
    if (bd_we) ram[bd_addr] <= bd_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: updates to one address are applied in acceptance order.
  task automatic model_apply(input int a, input int p, input int q, input bit d);
    int delta;
    int s;
    delta = (p * q) >> LrShift;
    s = d ? ref_w[a] - delta : ref_w[a] + delta;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    ref_w[a] = s;
    exp_addr.push_back(a);
    exp_data.push_back(s);
  endtask

  always @(negedge clk) begin
    if (!rst && we_b === 1'b1) begin
      if (exp_addr.size() == 0) begin
        check("wr_unexpected", 32'(we_b), 32'd0);
      end else begin
        check("wr_addr", 32'(addr_b), 32'(exp_addr.pop_front()));
        check("wr_data", 32'(din_b), exp_data.pop_front() & 32'hFFFF);
      end
    end
  end

  task automatic set_w(input int a, input int v);
    bd_we   = 1'b1;
    bd_addr = 10'(a);
    bd_data = 16'(v);
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    ref_w[a] = v;
  endtask

  // Drives a request and returns just after the accepting edge; in_valid stays high.
  task automatic send(input int a, input int p, input int q, input bit d, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    in_valid   = 1'b1;
    in_addr    = 10'(a);
    in_pre     = 8'(p);
    in_post    = 8'(q);
    in_depress = d;
    while (!ok && waited < 20) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      if (!ok) waited++;
    end
    if (ok) model_apply(a, p, q, d);
    else check("send_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w;
    int sn10;
    int sn11;
    int n;
    rst = 1'b1;
    bd_we = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    in_valid = 1'b1;
    in_addr = 10'd3;
    in_pre = 8'd200;
    in_post = 8'd200;
    in_depress = 1'b0;

    // Reset held 3 cycles with a request pending: nothing may be written.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c > 0) check("rst_we", 32'(we_b), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_we_after", 32'(we_b), 32'd0);
    check("rst_addr_a", 32'(addr_a), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NumW; i++) set_w(i, int'($urandom_range(0, 65535)) - 32768);

    // LTP: 100 + (16*32 >> 4) = 132, written exactly 4 cycles after accept.
    set_w(5, 100);
    send(5, 16, 32, 1'b0, w);
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("ltp_we", 32'(we_b), (c == 4) ? 32'd1 : 32'd0);
      if (c == 2) check("ltp_busy", 32'(busy), 32'd1);
      if (c == 4) begin
        check("ltp_addr", 32'(addr_b), 32'd5);
        check("ltp_din", 32'(din_b), 32'd132);
      end
      @(posedge clk);
      #1;
    end

    // LTD saturation: -32760 - 4064 clamps to -32768.
    set_w(7, -32760);
    send(7, 255, 255, 1'b1, w);
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) begin
        check("ltd_we", 32'(we_b), 32'd1);
        check("ltd_din", 32'(din_b), 32'h8000);
      end
      @(posedge clk);
      #1;
    end

    // Hazard: back-to-back to addr 9 -> stall cycles 1-3, accept in cycle 4.
    set_w(9, 0);
    in_valid = 1'b1;
    in_addr = 10'd9;
    in_pre = 8'd16;
    in_post = 8'd16;
    in_depress = 1'b0;
    @(negedge clk);
    check("haz_ready0", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    model_apply(9, 16, 16, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("haz_ready", 32'(in_ready), (c == 4) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    model_apply(9, 16, 16, 1'b0);
    idle(6);
    check("haz_ram9", 32'(ram[9]), 32'd32);

    // Streaming distinct addresses: no stalls, writes in cycles 4-7 in order.
    for (int a = 1; a <= 4; a++) begin
      send(a, 8 * a, 3 + a, a[0], w);
      check("stream_stall", 32'(w), 32'd0);
    end
    in_valid = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      check("stream_we", 32'(we_b), (c <= 7) ? 32'd1 : 32'd0);
      if (c <= 7) check("stream_addr", 32'(addr_b), 32'(c - 3));
      @(posedge clk);
      #1;
    end
    idle(2);

    // Reset mid-flight drops both updates.
    sn10 = ref_w[10];
    sn11 = ref_w[11];
    send(10, 100, 100, 1'b0, w);
    send(11, 100, 100, 1'b1, w);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_addr.delete();
    exp_data.delete();
    ref_w[10] = sn10;
    ref_w[11] = sn11;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("midrst_we", 32'(we_b), 32'd0);
      @(posedge clk);
      #1;
    end
    check("midrst_ram10", 32'(ram[10]), sn10 & 32'hFFFF);
    check("midrst_ram11", 32'(ram[11]), sn11 & 32'hFFFF);

    // Random traffic over a small address window to provoke hazards.
    for (int k = 0; k < 80; k++) begin
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), w);
      idle(int'($urandom_range(0, 2)));
    end

    in_valid = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_queue", 32'(exp_addr.size()), 32'd0);
    for (int i = 0; i < NumW; i++) check("final_ram", 32'(ram[i]), ref_w[i] & 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/boreal_hebbian_updater.md
# boreal_hebbian_updater

Pipelined Hebbian plasticity engine sitting alongside the `boreal_memory` weight BRAM. It accepts weight-update requests (address plus pre/post-synaptic traces) over a valid/ready handshake. It fetches the current weight through the BRAM read port, which has 2-cycle read latency, computes a saturating Hebbian delta, and writes the result back through the BRAM write port. Read-after-write hazards on the same address are resolved by stalling, so every update sees the previous update's result.

## Interface
- `ADDR_WIDTH`, 10: weight address width; matches the BRAM.
- `DATA_WIDTH`, 16: weight width; two's-complement signed.
- `TRACE_WIDTH`, 8: unsigned pre/post trace width.
- `LR_SHIFT`, 4: learning-rate right shift applied to the trace product.
- `W_MAX`, 32767: upper clamp; signed, DATA_WIDTH bits.
- `W_MIN`, -32768: lower clamp; W_MIN ≤ W_MAX.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  update request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_addr`  in  ADDR_WIDTH  weight address.
- `in_pre`  in  TRACE_WIDTH  pre-synaptic trace.
- `in_post`  in  TRACE_WIDTH  post-synaptic trace.
- `in_depress`  in  1  1 = subtract delta (LTD); 0 = add delta (LTP).
- `addr_a`  out  ADDR_WIDTH  BRAM read address, registered.
- `dout_a`  in  DATA_WIDTH  BRAM read data, valid 2 cycles after `addr_a`.
- `we_b`  out  1  BRAM write enable, registered.
- `addr_b`  out  ADDR_WIDTH  BRAM write address, registered.
- `din_b`  out  DATA_WIDTH  BRAM write data, registered.
- `busy`  out  1  any pipeline stage valid.

## Operation
- Four stages, each with a valid bit, address, traces and depress flag:
  - S1: `addr_a` is presented.
  - S2: waiting on the BRAM.
  - S3: `dout_a` is valid; compute.
  - S4: write outputs are driven.
- Pipeline advances every cycle; it never back-pressures internally, because the BRAM write port is always ready.
- Arithmetic:
  - product = `in_pre * in_post`, unsigned, 2·TRACE_WIDTH bits.
  - delta = product >> LR_SHIFT, zero-extended to DATA_WIDTH+2 signed.
  - sum = sext(w) ± delta, with w = `dout_a` and the sign chosen by `in_depress`.
  - result = clamp(sum, W_MIN, W_MAX).
  - Result is truncated to DATA_WIDTH only after the clamp. No wrap is ever permitted.
- A delta of 0 still performs the write, which rewrites the same value.
- Hazard rule: `in_ready` = 0 when `in_addr` equals the address of any valid S1, S2 or S3 entry. A match in S4 alone does not stall, since the write lands before the new read is sampled.
- `in_ready` depends combinationally on `in_addr`. Requesters must hold `in_valid` and the payload stable until accepted.
- Different-address requests stream at 1 per cycle.
- Reset:
  - Clears all stage valids and the address registers.
  - Outputs return to `we_b`=0, `addr_a`=0, `addr_b`=0, `din_b`=0, `busy`=0.
  - In-flight updates are dropped, not written.
  - `in_ready` is 1 in the first cycle after `rst` deasserts.

## Timing
- Request accepted in cycle 0 → `addr_a` valid cycle 1 → `dout_a` valid cycle 3 → `we_b`/`addr_b`/`din_b` valid cycle 4 → RAM updated at the end of cycle 4.
- Latency from accept to `we_b` is 4 cycles. Throughput is 1 update/cycle for distinct addresses.
- A same-address follow-up is held off in cycles 1–3 and accepted in cycle 4 at the earliest. Its read then occurs after the prior write.
- `we_b` is high for exactly one cycle per accepted request.
- `rst` asserted in any cycle suppresses `we_b` from the next cycle onward.

## Structure
- Shared package `boreal_pkg`:
  - Constants: ADDR_WIDTH, DATA_WIDTH, TRACE_WIDTH defaults.
  - Types: `weight_t` (signed DATA_WIDTH) and the pipeline-stage struct (valid, addr, pre, post, depress).
- Sub-module `boreal_hebb_delta`: purely combinational product, shift, signed add and clamp. It is instantiated once in S3 and is unit-testable alone.

## Test plan
- Reset: hold `rst` for 3 cycles with `in_valid`=1 → no `we_b`. After release, `busy`=0 and `in_ready`=1.
- LTP: ram[5]=100; request addr 5, pre=16, post=32, depress=0, LR_SHIFT=4 → delta=32. `we_b` in cycle 4 with `addr_b`=5 and `din_b`=132.
- LTD saturation: ram[7]=-32760; request pre=255, post=255, depress=1 → delta=4064. `din_b`=-32768 (clamped, no wrap).
- Hazard: two back-to-back requests to addr 9 (pre=16, post=16, ram[9]=0) → `in_ready` low in cycles 1–3. Second request accepted in cycle 4. Writes are 16 then 32.
- Streaming: addrs 1, 2, 3, 4 in consecutive cycles → no stalls. `we_b` high in cycles 4–7 with matching `addr_b` order.
- Reset mid-flight: accept addrs 10 and 11, then assert `rst` in cycle 2 → `we_b` never asserts and ram[10]/ram[11] are unchanged.
